javi_sum_uart_tx: RTL

Downstream stage of the tile's 8-bit adder datapath. It accepts each computed sum byte over a valid/ready handshake and serialises it as an 8N1 UART frame on a single output pin, so results can be read by a host.
- One holding register plus one shift register give 2-byte buffering, so back-to-back frames are sent with no idle gap.
- A wrapping frame counter is provided for debug and status pins.

---
 rtl/javi_sum_uart_tx.sv | 136 +++++++++++++
 1 files changed

// File: rtl/javi_sum_uart_tx.sv
// 8N1 UART transmitter for the adder's sum bytes: valid/ready intake into a
// holding register, with a separate shift register so buffered frames run back-to-back.
module javi_sum_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic [7:0] frames_sent
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    state_e           state_q, state_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [7:0]       shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic             tx_q, tx_d;
    logic [7:0]       frames_q, frames_d;
    logic             cnt_last;

    assign cnt_last    = (cnt_q == CNT_LAST);
    assign in_ready    = ~hold_full_q;
    assign tx          = tx_q;
    assign busy        = (state_q != IDLE);
    assign frames_sent = frames_q;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        tx_d        = tx_q;
        frames_d    = frames_q;

        // Accept only depends on registered hold_full_q, and the drain paths
        // below only fire when hold_full_q is set, so they never overlap.
        if (in_valid && !hold_full_q) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (hold_full_q) begin
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                    tx_d        = 1'b0;
                    cnt_d       = '0;
                    state_d     = START;
                end
            end
            START: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_last) begin
                    cnt_d    = '0;
                    frames_d = frames_q + 8'd1;
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        tx_d        = 1'b0;
                        state_d     = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            cnt_q       <= '0;
            bit_q       <= '0;
            tx_q        <= 1'b1;
            frames_q    <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            tx_q        <= tx_d;
            frames_q    <= frames_d;
        end
    end

endmodule
